// File: rtl/beta_regfile_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : beta_regfile_hazard_if
// Purpose  : Decode-side bundle between the decode stage and the register file.
// Revision : 1.0
// ============================================================================
interface beta_regfile_hazard_if #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NSTAGES = 3
);
  localparam int AW = $clog2(NREGS);

  logic                       dec_valid;
  logic [NRD*AW-1:0]          dec_ra;
  logic [NRD-1:0]             dec_ruse;
  logic [AW-1:0]              dec_rc;
  logic                       dec_wen;
  logic                       dec_is_load;
  logic                       flush;
  logic [NSTAGES*WIDTH-1:0]   byp_data;
  logic [NRD*WIDTH-1:0]       rd;
  logic                       stall;

  modport master (
    output dec_valid, dec_ra, dec_ruse, dec_rc, dec_wen, dec_is_load, flush, byp_data,
    input  rd, stall
  );

  modport slave (
    input  dec_valid, dec_ra, dec_ruse, dec_rc, dec_wen, dec_is_load, flush, byp_data,
    output rd, stall
  );
endinterface
`default_nettype wire

// File: rtl/beta_regfile_hazard.sv
`default_nettype none
// ============================================================================
// Module   : beta_regfile_hazard
// Purpose  : Beta register file with destination-tag tracking, youngest-match
//            forwarding, load-use stall and commit from the last stage.
// Revision : 1.0
// ============================================================================
module beta_regfile_hazard #(
  parameter int WIDTH      = 32,
  parameter int NREGS      = 32,
  parameter int NRD        = 2,
  parameter int NSTAGES    = 3,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_REG   = NREGS - 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  beta_regfile_hazard_if.slave bus
);
  localparam int            AW        = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  // Tracker: one {v, rc, ld} tag per downstream stage, index 0 is youngest.
  logic [NSTAGES-1:0] stg_v_q,  stg_v_d;
  logic [NSTAGES-1:0] stg_ld_q, stg_ld_d;
  logic [AW-1:0]      stg_rc_q [NSTAGES];
  logic [AW-1:0]      stg_rc_d [NSTAGES];

  logic [WIDTH-1:0]   mem_q [NREGS];
  logic [WIDTH-1:0]   mem_d [NREGS];

  logic [AW-1:0]      port_ra [NRD];
  logic [NRD-1:0]     hazard;
  logic [NRD*WIDTH-1:0] rd_all;
  logic               stall_w;
  logic               accept_w;

  for (genvar i = 0; i < NRD; i++) begin : g_ra
    assign port_ra[i] = bus.dec_ra[i*AW +: AW];
  end

  // Scanning oldest-to-youngest lets the youngest match overwrite older ones.
  always_comb begin
    hazard = '0;
    rd_all = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_all[i*WIDTH +: WIDTH] = mem_q[port_ra[i]];
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (stg_v_q[k] && (stg_rc_q[k] == port_ra[i])) begin
          rd_all[i*WIDTH +: WIDTH] = bus.byp_data[k*WIDTH +: WIDTH];
          hazard[i]                = stg_ld_q[k] && (k < LOAD_STAGE);
        end
      end
      if (port_ra[i] == ZERO_ADDR) begin
        rd_all[i*WIDTH +: WIDTH] = '0;
        hazard[i]                = 1'b0;
      end
    end
  end

  assign stall_w  = bus.dec_valid && !bus.flush && |(bus.dec_ruse & hazard);
  assign accept_w = bus.dec_valid && bus.dec_wen && !stall_w && !bus.flush &&
                    (bus.dec_rc != ZERO_ADDR);

  assign bus.rd    = rd_all;
  assign bus.stall = stall_w;

  // Flush kills the entry that is moving out of stage 0 as well as decode.
  always_comb begin
    stg_v_d     = '0;
    stg_ld_d    = '0;
    stg_rc_d    = stg_rc_q;
    stg_v_d[0]  = accept_w;
    stg_ld_d[0] = bus.dec_is_load;
    stg_rc_d[0] = bus.dec_rc;
    for (int k = 1; k < NSTAGES; k++) begin
      stg_v_d[k]  = stg_v_q[k-1] && !(bus.flush && (k == 1));
      stg_ld_d[k] = stg_ld_q[k-1];
      stg_rc_d[k] = stg_rc_q[k-1];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (stg_v_q[NSTAGES-1] && (stg_rc_q[NSTAGES-1] != ZERO_ADDR)) begin
      mem_d[stg_rc_q[NSTAGES-1]] = bus.byp_data[(NSTAGES-1)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v_q  <= '0;
      stg_ld_q <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        stg_rc_q[k] <= '0;
      end
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      stg_v_q  <= stg_v_d;
      stg_ld_q <= stg_ld_d;
      stg_rc_q <= stg_rc_d;
      mem_q    <= mem_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_beta_regfile_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_regfile_hazard
// Purpose  : Directed bench for beta_regfile_hazard with an in-flight-list model.
// Revision : 1.0
// ============================================================================
module tb_beta_regfile_hazard;
  localparam int WIDTH      = 32;
  localparam int NREGS      = 32;
  localparam int NRD        = 2;
  localparam int NSTAGES    = 3;
  localparam int LOAD_STAGE = 2;
  localparam int ZREG       = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  beta_regfile_hazard_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .NSTAGES(NSTAGES)) bus ();

  beta_regfile_hazard #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .NSTAGES(NSTAGES),
    .LOAD_STAGE(LOAD_STAGE), .ZERO_REG(ZREG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: list of in-flight writes with their age (stage index) and result.
  typedef struct {
    int          rc;
    bit          ld;
    int          age;
    logic [31:0] val;
  } ent_t;

  ent_t        pipe [$];
  logic [31:0] mmem [NREGS];

  bit          cur_valid, cur_wen, cur_ld, cur_fl;
  logic [4:0]  cur_ra [NRD];
  logic [1:0]  cur_ruse;
  int          cur_rc;
  logic [31:0] cur_res;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_read(input logic [4:0] ra, output logic [31:0] v, output bit h);
    int best;
    best = -1;
    v    = '0;
    h    = 1'b0;
    if (int'(ra) == ZREG) return;
    foreach (pipe[j]) begin
      if (pipe[j].rc == int'(ra) && (best < 0 || pipe[j].age < pipe[best].age)) best = j;
    end
    if (best >= 0) begin
      v = pipe[best].val;
      h = pipe[best].ld && (pipe[best].age < LOAD_STAGE);
    end else begin
      v = mmem[ra];
    end
  endfunction

  function automatic bit exp_stall();
    logic [31:0] v;
    bit          h;
    bit          any;
    any = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      exp_read(cur_ra[i], v, h);
      if (cur_ruse[i] && h) any = 1'b1;
    end
    return cur_valid && !cur_fl && any;
  endfunction

  function automatic logic [NSTAGES*WIDTH-1:0] model_byp();
    logic [NSTAGES*WIDTH-1:0] b;
    for (int k = 0; k < NSTAGES; k++) b[k*WIDTH +: WIDTH] = 32'hBAD0_0000 | 32'(k);
    foreach (pipe[j]) b[pipe[j].age*WIDTH +: WIDTH] = pipe[j].val;
    return b;
  endfunction

  function automatic void model_clear();
    pipe.delete();
    for (int r = 0; r < NREGS; r++) mmem[r] = '0;
  endfunction

  function automatic void advance();
    bit s;
    s = exp_stall();
    for (int i = pipe.size() - 1; i >= 0; i--) begin
      if (pipe[i].age == NSTAGES - 1) begin
        mmem[pipe[i].rc] = pipe[i].val;
        pipe.delete(i);
      end else if (cur_fl && pipe[i].age == 0) begin
        pipe.delete(i);
      end else begin
        pipe[i].age++;
      end
    end
    if (cur_valid && cur_wen && !s && !cur_fl && cur_rc != ZREG)
      pipe.push_back('{rc: cur_rc, ld: cur_ld, age: 0, val: cur_res});
  endfunction

  task automatic drive(input bit v, input int ra0, input int ra1, input logic [1:0] ruse,
                       input int rc, input bit wen, input bit ld, input bit fl,
                       input logic [31:0] res);
    cur_valid = v;   cur_ra[0] = ra0[4:0]; cur_ra[1] = ra1[4:0]; cur_ruse = ruse;
    cur_rc    = rc;  cur_wen   = wen;      cur_ld    = ld;        cur_fl   = fl;
    cur_res   = res;
    bus.dec_valid   = v;
    bus.dec_ra      = {cur_ra[1], cur_ra[0]};
    bus.dec_ruse    = ruse;
    bus.dec_rc      = rc[4:0];
    bus.dec_wen     = wen;
    bus.dec_is_load = ld;
    bus.flush       = fl;
    bus.byp_data    = model_byp();
  endtask

  task automatic idle(input int ra0, input int ra1);
    drive(1'b0, ra0, ra1, 2'b00, 0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic settle_tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.byp_data = model_byp();
      tick();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  // Every cycle: each non-hazarded port and stall against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ev;
      bit          eh;
      for (int i = 0; i < NRD; i++) begin
        exp_read(cur_ra[i], ev, eh);
        if (!eh) check($sformatf("rd%0d_model", i), bus.rd[i*WIDTH +: WIDTH], ev);
      end
      check("stall_model", {31'b0, bus.stall}, {31'b0, exp_stall()});
    end
  end

  initial begin
    model_clear();
    idle(0, 5);
    chk_en = 1'b1;
    #2;
    check("reset_rd0_r0", bus.rd[31:0], 32'h0);
    check("reset_rd1_r5", bus.rd[63:32], 32'h0);
    check("reset_stall", {31'b0, bus.stall}, 32'h0);
    release_reset();

    // Write R5 and let it commit.
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 32'hDEAD_BEEF); tick();
    idle(5, 0); #2;
    check("fwd_r5_stage0", bus.rd[31:0], 32'hDEAD_BEEF);
    tick(); settle_tick(2);
    idle(5, 0); #2;
    check("commit_r5", bus.rd[31:0], 32'hDEAD_BEEF);
    tick();

    // Two writes to R3 in flight: youngest must win.
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 32'h11); tick();
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 32'h22); tick();
    drive(1, 3, 3, 2'b11, 4, 1, 0, 0, 32'h44); #2;
    check("youngest_r3", bus.rd[31:0], 32'h22);
    check("youngest_stall", {31'b0, bus.stall}, 32'h0);
    tick(); settle_tick(4);

    // Load-use: two stall cycles, then forward from stage 2.
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 32'h77); tick();
    drive(1, 7, 3, 2'b01, 9, 1, 0, 0, 32'h99); #2;
    check("ld_stall_c1", {31'b0, bus.stall}, 32'h1);
    tick();
    drive(1, 7, 3, 2'b01, 9, 1, 0, 0, 32'h99); #2;
    check("ld_stall_c2", {31'b0, bus.stall}, 32'h1);
    tick();
    drive(1, 7, 3, 2'b01, 9, 1, 0, 0, 32'h99); #2;
    check("ld_stall_done", {31'b0, bus.stall}, 32'h0);
    check("ld_fwd_stage2", bus.rd[31:0], 32'h77);
    tick(); settle_tick(4);

    // Unused operand never stalls.
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 32'h78); tick();
    drive(1, 7, 7, 2'b00, 8, 1, 0, 0, 32'h88); #2;
    check("ld_unused_nostall", {31'b0, bus.stall}, 32'h0);
    tick(); settle_tick(4);

    // Writes to the zero register are ignored.
    drive(1, 31, 31, 2'b11, 31, 1, 0, 0, 32'hFFFF_FFFF); #2;
    check("zero_rd0", bus.rd[31:0], 32'h0);
    tick();
    idle(31, 31); settle_tick(4);
    idle(31, 31); #2;
    check("zero_after", bus.rd[63:32], 32'h0);
    tick();

    // Flush kills a pending load hazard and the load itself.
    drive(1, 0, 0, 2'b00, 10, 1, 0, 0, 32'h1234); tick();
    idle(0, 0); settle_tick(4);
    drive(1, 0, 0, 2'b00, 10, 1, 1, 0, 32'hAA); tick();
    drive(1, 10, 0, 2'b01, 11, 1, 0, 1, 32'hBB); #2;
    check("flush_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    drive(1, 10, 11, 2'b11, 12, 1, 0, 0, 32'hCC); #2;
    check("flush_old_r10", bus.rd[31:0], 32'h1234);
    check("flush_r11_untracked", bus.rd[63:32], 32'h0);
    tick(); settle_tick(4);

    // Reset with three writes in flight.
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 32'h101); tick();
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 32'h202); tick();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 32'h404); tick();
    rst = 1'b1;
    model_clear();
    idle(1, 2); #2;
    check("rst_mid_r1", bus.rd[31:0], 32'h0);
    check("rst_mid_r2", bus.rd[63:32], 32'h0);
    release_reset();
    idle(4, 5); settle_tick(3);
    idle(4, 5); #2;
    check("rst_after_r4", bus.rd[31:0], 32'h0);
    check("rst_after_r5", bus.rd[63:32], 32'h0);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/beta_regfile_hazard.md
# beta_regfile_hazard

Parametrised register file with integrated pipeline hazard tracking for the Beta CPU. It holds the architectural registers and tracks in-flight destination registers across NSTAGES downstream stages. It forwards results from the youngest matching stage, raises load-use stalls, and commits writes from the final stage. It sits between the decode stage and the execute/memory/write-back stages. The pipeline control that previously had to be fed in per stage is now generated internally from a shift register of destination tags.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; AW = $clog2(NREGS)
- NRD, 2, number of read ports
- NSTAGES, 3, tracked downstream stages (0 = exec, NSTAGES-1 = write-back)
- LOAD_STAGE, 2, first stage index at which load data is valid on byp_data
- ZERO_REG, NREGS-1, register that always reads 0 and is never written

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode slot holds a valid instruction
- dec_ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- dec_ruse  in  NRD  port i operand is actually consumed (e.g. Rb only for OP class)
- dec_rc  in  AW  destination register of the decode instruction
- dec_wen  in  1  decode instruction writes dec_rc
- dec_is_load  in  1  decode instruction is LD/LDR
- flush  in  1  kill the decode instruction and the entry leaving stage 0
- byp_data  in  NSTAGES*WIDTH  result currently held in stage k, at [k*WIDTH +: WIDTH]
- rd  out  NRD*WIDTH  read data per port
- stall  out  1  hold decode; a bubble enters stage 0

## Operation
- Tracker: one entry per stage, {v, rc, ld}. All entries are cleared on rst.
- Each clock, when not in reset:
  - stage[0] ← {1, dec_rc, dec_is_load} if dec_valid && dec_wen && !stall && !flush && dec_rc != ZERO_REG; otherwise invalid.
  - stage[k] ← stage[k-1] for k ≥ 1.
  - If flush, stage[1] ← invalid.
- Commit: if stage[NSTAGES-1].v, then mem[stage[NSTAGES-1].rc] ← byp_data[NSTAGES-1] at the clock edge.
- Reset: all registers clear to 0.
- Read, per port i, evaluated combinationally:
  - If ra == ZERO_REG, rd = 0.
  - Otherwise, find the lowest k (youngest) with stage[k].v && stage[k].rc == ra:
    - If stage[k].ld && k < LOAD_STAGE, the port is hazarded and rd is don't-care.
    - Otherwise rd = byp_data[k].
  - If no stage matches, rd = mem[ra].
- Youngest-match priority is mandatory. An older match must never override a younger one.
- stall = dec_valid && !flush && OR over i of (dec_ruse[i] && hazard[i]).
- Unused ports (dec_ruse[i] = 0) never cause a stall. They still return forwarded or stored data.
- Write-through needs no separate path: the committing value is byp_data[NSTAGES-1] during the commit cycle.

## Timing
- Read path: combinational, 0-cycle latency from dec_ra/tracker/byp_data to rd.
- Tracker and commit: single cycle per stage. An instruction accepted at edge t commits at edge t+NSTAGES.
- Load-use: when a load in stage 0 is consumed by the next instruction, stall is asserted for LOAD_STAGE cycles (default 2). The operand is then forwarded from stage LOAD_STAGE.
- Reset state: every tracker entry invalid, stall = 0, every mem = 0, so rd = 0 for all addresses.
- Reset asserted mid-operation: all tracker entries and registers clear immediately; in-flight writes are lost.
- Simultaneous commit and read of the same register: the forwarded value is returned, which equals the committing value.
- flush with stall: flush wins; stall = 0 and nothing enters stage 0.
- A write to ZERO_REG is never tracked and never committed.

## Test plan
- After rst: read R0 and R5 → rd = 0, stall = 0. Commit 0xDEADBEEF to R5 through all stages, then read R5 with no matches → 0xDEADBEEF.
- Back-to-back ALU writes R3 = 0x11 (now in stage 1) and R3 = 0x22 (now in stage 0), then decode reads R3 → rd = byp_data[0] = 0x22 (youngest wins), stall = 0.
- LD R7 in stage 0, decode reads R7 on port 0 with dec_ruse = 1 → stall high for 2 cycles, then rd = byp_data[2] with stall = 0. Same setup with dec_ruse = 0 → no stall.
- Write R31 (ZERO_REG) with 0xFFFFFFFF → never tracked; reading R31 returns 0 on every cycle.
- Load hazard pending, flush asserted → stall = 0 that cycle; the stage-0 entry is invalidated into stage 1, and a subsequent read of its rc returns the old mem value.
- rst pulsed while three writes are in flight → all tracker entries clear, no commit occurs, and all reads return 0.
